// File: rtl/apu_pulse_bank.sv
// Bank of NES-style pulse channels behind a shared 4-byte-per-channel register window.
// Each channel has a timer, duty sequencer, envelope, length counter and sweep unit,
// and produces a registered 4-bit sample for the mixer.
module apu_pulse_bank #(
  parameter int unsigned         CHANNELS       = 2,
  parameter logic [15:0]         BASE_ADDR      = 16'h4000,
  parameter int unsigned         TIMER_BITS     = 11,
  parameter logic [CHANNELS-1:0] ONES_COMP_MASK = CHANNELS'(1)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  cpu_cycle_pulse_in,
  input  logic                  lc_pulse_in,
  input  logic                  eg_pulse_in,
  input  logic [15:0]           a_in,
  input  logic [7:0]            d_in,
  input  logic                  r_nw_in,
  input  logic [CHANNELS-1:0]   en_in,
  output logic [4*CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0]   active_out
);

  localparam int unsigned TW = TIMER_BITS + 1;

  logic        apu_phase;
  logic        tick;
  logic [16:0] offset;
  logic        in_window;
  logic        wr;
  logic [1:0]  wr_reg;
  logic [13:0] wr_idx;

  // APU-cycle divider: timers tick on every second CPU cycle strobe
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      apu_phase <= 1'b0;
    end else if (cpu_cycle_pulse_in) begin
      apu_phase <= ~apu_phase;
    end
  end

  assign tick      = cpu_cycle_pulse_in & apu_phase;
  assign offset    = {1'b0, a_in} - {1'b0, BASE_ADDR};
  assign in_window = !offset[16] && (offset < 17'(4 * CHANNELS));
  assign wr        = !r_nw_in && in_window;
  assign wr_reg    = offset[1:0];
  assign wr_idx    = offset[15:2];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic                  sel;
    logic                  wr0, wr1, wr2, wr3;
    logic [1:0]            duty;
    logic                  halt;
    logic                  constv;
    logic [3:0]            vol;
    logic                  sweep_en;
    logic [2:0]            sweep_per;
    logic                  negate;
    logic [2:0]            shift;
    logic [TIMER_BITS-1:0] period;
    logic [TIMER_BITS-1:0] timer;
    logic [2:0]            step;
    logic                  env_start;
    logic [3:0]            decay;
    logic [3:0]            env_div;
    logic [5:0]            length;
    logic [2:0]            sweep_div;
    logic                  sweep_reload;
    logic [3:0]            sample;
    logic [7:0]            pattern;
    logic [TW-1:0]         change;
    logic [TW-1:0]         target;
    logic                  mute;
    logic [3:0]            volume;

    assign sel = wr && (wr_idx == 14'(k));
    assign wr0 = sel && (wr_reg == 2'd0);
    assign wr1 = sel && (wr_reg == 2'd1);
    assign wr2 = sel && (wr_reg == 2'd2);
    assign wr3 = sel && (wr_reg == 2'd3);

    // Duty waveform lookup, indexed by the sequencer step
    always_comb begin
      pattern = '0;
      case (duty)
        2'd0:    pattern = 8'b0100_0000;
        2'd1:    pattern = 8'b0110_0000;
        2'd2:    pattern = 8'b0111_1000;
        default: pattern = 8'b1001_1111;
      endcase
    end

    // Sweep target and mute are evaluated continuously, not only on sweep clocks
    always_comb begin
      change = {1'b0, period} >> shift;
      if (negate) begin
        target = {1'b0, period} - change - TW'(ONES_COMP_MASK[k]);
      end else begin
        target = {1'b0, period} + change;
      end
      mute   = (period < TIMER_BITS'(8)) || (!negate && target[TIMER_BITS]);
      volume = constv ? vol : decay;
    end

    // Control registers r0 and r1
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        duty      <= '0;
        halt      <= 1'b0;
        constv    <= 1'b0;
        vol       <= '0;
        sweep_en  <= 1'b0;
        sweep_per <= '0;
        negate    <= 1'b0;
        shift     <= '0;
      end else begin
        if (wr0) begin
          duty   <= d_in[7:6];
          halt   <= d_in[5];
          constv <= d_in[4];
          vol    <= d_in[3:0];
        end
        if (wr1) begin
          sweep_en  <= d_in[7];
          sweep_per <= d_in[6:4];
          negate    <= d_in[3];
          shift     <= d_in[2:0];
        end
      end
    end

    // Period and sweep unit; a register write lands after the sweep so it takes precedence
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        period       <= '0;
        sweep_div    <= '0;
        sweep_reload <= 1'b0;
      end else begin
        if (lc_pulse_in) begin
          if ((sweep_div == 3'd0) && sweep_en && (shift != 3'd0) && !mute) begin
            period <= target[TIMER_BITS-1:0];
          end
          if ((sweep_div == 3'd0) || sweep_reload) begin
            sweep_div    <= sweep_per;
            sweep_reload <= 1'b0;
          end else begin
            sweep_div <= sweep_div - 3'd1;
          end
        end
        if (wr2) period[7:0] <= d_in;
        if (wr3) period[TIMER_BITS-1:8] <= d_in[TIMER_BITS-9:0];
        if (wr1) sweep_reload <= 1'b1;
      end
    end

    // Timer and duty sequencer; r3 write restarts the sequence but not the count
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        timer <= '0;
        step  <= '0;
      end else begin
        if (tick) begin
          if (timer == '0) begin
            timer <= period;
            step  <= step - 3'd1;
          end else begin
            timer <= timer - TIMER_BITS'(1);
          end
        end
        if (wr3) step <= '0;
      end
    end

    // Envelope generator
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        env_start <= 1'b0;
        decay     <= '0;
        env_div   <= '0;
      end else begin
        if (eg_pulse_in) begin
          if (env_start) begin
            env_start <= 1'b0;
            decay     <= 4'd15;
            env_div   <= vol;
          end else if (env_div == 4'd0) begin
            env_div <= vol;
            if (decay != 4'd0) begin
              decay <= decay - 4'd1;
            end else if (halt) begin
              decay <= 4'd15;
            end
          end else begin
            env_div <= env_div - 4'd1;
          end
        end
        if (wr3) env_start <= 1'b1;
      end
    end

    // Length counter: disable clears, load beats a coincident decrement
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        length <= '0;
      end else if (!en_in[k]) begin
        length <= '0;
      end else if (wr3) begin
        length <= {d_in[7:3], 1'b1};
      end else if (lc_pulse_in && (length != 6'd0) && !halt) begin
        length <= length - 6'd1;
      end
    end

    // Registered output sample
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        sample <= '0;
      end else if (pattern[step] && (length != 6'd0) && !mute && en_in[k]) begin
        sample <= volume;
      end else begin
        sample <= '0;
      end
    end

    assign pulse_out[4*k +: 4] = sample;
    assign active_out[k]       = (length != 6'd0);
  end

endmodule

// File: tb/tb_apu_pulse_bank.sv
// Directed testbench for apu_pulse_bank (4 channels at 0x5000, ch0 ones'-complement sweep).
module tb_apu_pulse_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu = 1'b0;
  logic        lc = 1'b0;
  logic        eg = 1'b0;
  logic [15:0] a = '0;
  logic [7:0]  d = '0;
  logic        r_nw = 1'b1;
  logic [3:0]  en = '0;
  logic [15:0] pulse;
  logic [3:0]  active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apu_pulse_bank #(
    .CHANNELS(4),
    .BASE_ADDR(16'h5000),
    .TIMER_BITS(11),
    .ONES_COMP_MASK(4'b0001)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .cpu_cycle_pulse_in(cpu),
    .lc_pulse_in(lc),
    .eg_pulse_in(eg),
    .a_in(a),
    .d_in(d),
    .r_nw_in(r_nw),
    .en_in(en),
    .pulse_out(pulse),
    .active_out(active)
  );

  task automatic wr_addr(input logic [15:0] addr, input logic [7:0] val, input logic with_lc);
    @(negedge clk);
    a = addr; d = val; r_nw = 1'b0; lc = with_lc;
    @(negedge clk);
    r_nw = 1'b1; lc = 1'b0;
  endtask

  task automatic wr(input int ch, input int r, input logic [7:0] val);
    wr_addr(16'h5000 + 16'(ch * 4 + r), val, 1'b0);
  endtask

  task automatic pulse_lc();
    @(negedge clk); lc = 1'b1;
    @(negedge clk); lc = 1'b0;
  endtask

  task automatic pulse_eg();
    @(negedge clk); eg = 1'b1;
    @(negedge clk); eg = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Measures one full high phase and the following low phase of a channel, in clocks.
  task automatic measure(input int ch, output int hi, output int lo, output logic [3:0] level, output bit ok);
    int n;
    ok = 1'b1; hi = 0; lo = 0; level = '0;
    n = 0;
    while (pulse[ch*4 +: 4] != 4'd0 && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) ok = 1'b0;
    n = 0;
    while (pulse[ch*4 +: 4] == 4'd0 && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) ok = 1'b0;
    level = pulse[ch*4 +: 4];
    while (pulse[ch*4 +: 4] != 4'd0 && hi < 20000) begin @(negedge clk); hi++; end
    while (pulse[ch*4 +: 4] == 4'd0 && lo < 20000) begin @(negedge clk); lo++; end
    if (hi >= 20000 || lo >= 20000) ok = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if (pulse !== 16'h0000) begin errors++; $display("FAIL reset_pulse: got %h expected 0000", pulse); end
    checks++;
    if (active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", active); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int hi, lo; logic [3:0] lvl; bit ok;
    cpu = 1'b1;
    en = 4'b0001;
    wr(0, 0, 8'hBF);
    wr(0, 2, 8'h08);
    wr(0, 3, 8'h08);
    checks++;
    if (active !== 4'b0001) begin errors++; $display("FAIL basic_active: got %b expected 0001", active); end
    measure(0, hi, lo, lvl, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got timeout expected edges"); end
    checks++;
    if (hi !== 72) begin errors++; $display("FAIL basic_high_width: got %0d expected 72", hi); end
    checks++;
    if (lo !== 72) begin errors++; $display("FAIL basic_low_width: got %0d expected 72", lo); end
    checks++;
    if (lvl !== 4'd15) begin errors++; $display("FAIL basic_level: got %0d expected 15", lvl); end
  endtask

  task automatic test_length();
    cpu = 1'b0;
    wr(0, 0, 8'hDF);
    wr(0, 3, 8'h00);
    checks++;
    if (active[0] !== 1'b1) begin errors++; $display("FAIL len_load: got %b expected 1", active[0]); end
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd15) begin errors++; $display("FAIL len_out_before: got %0d expected 15", pulse[3:0]); end
    pulse_lc();
    checks++;
    if (active[0] !== 1'b0) begin errors++; $display("FAIL len_expire: got %b expected 0", active[0]); end
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd0) begin errors++; $display("FAIL len_out_after: got %0d expected 0", pulse[3:0]); end
    wr(0, 0, 8'hFF);
    wr(0, 3, 8'h00);
    pulse_lc();
    checks++;
    if (active[0] !== 1'b1) begin errors++; $display("FAIL len_halt: got %b expected 1", active[0]); end
    wr(0, 0, 8'hDF);
    wr_addr(16'h5003, 8'h00, 1'b1);
    checks++;
    if (active[0] !== 1'b1) begin errors++; $display("FAIL len_load_wins: got %b expected 1", active[0]); end
    pulse_lc();
    checks++;
    if (active[0] !== 1'b0) begin errors++; $display("FAIL len_after_load_wins: got %b expected 0", active[0]); end
    en = 4'b0000;
    wr(0, 3, 8'h08);
    checks++;
    if (active[0] !== 1'b0) begin errors++; $display("FAIL len_disabled_load: got %b expected 0", active[0]); end
    en = 4'b0001;
    wr(0, 3, 8'h08);
    en = 4'b0000;
    idle(1);
    checks++;
    if (active[0] !== 1'b0) begin errors++; $display("FAIL len_disable_clear: got %b expected 0", active[0]); end
    en = 4'b0001;
  endtask

  task automatic test_envelope();
    cpu = 1'b0;
    wr(0, 0, 8'hC3);
    wr(0, 3, 8'h08);
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd0) begin errors++; $display("FAIL env_initial: got %0d expected 0", pulse[3:0]); end
    pulse_eg();
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd15) begin errors++; $display("FAIL env_start: got %0d expected 15", pulse[3:0]); end
    for (int i = 0; i < 15; i++) begin
      repeat (4) pulse_eg();
      idle(1);
      checks++;
      if (pulse[3:0] !== 4'(14 - i)) begin
        errors++; $display("FAIL env_decay_%0d: got %0d expected %0d", i, pulse[3:0], 14 - i);
      end
    end
    repeat (4) pulse_eg();
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd0) begin errors++; $display("FAIL env_hold: got %0d expected 0", pulse[3:0]); end
    wr(0, 0, 8'hE3);
    repeat (4) pulse_eg();
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd15) begin errors++; $display("FAIL env_loop: got %0d expected 15", pulse[3:0]); end
  endtask

  task automatic test_sweep();
    int hi, lo; logic [3:0] lvl; bit ok;
    cpu = 1'b1;
    en = 4'b0011;
    wr(0, 0, 8'h3F);
    wr(0, 1, 8'h81);
    wr(0, 2, 8'h00);
    wr(0, 3, 8'h09);
    pulse_lc();
    measure(0, hi, lo, lvl, ok);
    checks++;
    if (!ok || hi !== 770) begin errors++; $display("FAIL sweep_add: got %0d expected 770", hi); end
    checks++;
    if (lvl !== 4'd15) begin errors++; $display("FAIL sweep_level: got %0d expected 15", lvl); end
    wr(0, 1, 8'h89);
    wr(0, 2, 8'h00);
    wr(0, 3, 8'h09);
    wr(1, 0, 8'h3F);
    wr(1, 1, 8'h89);
    wr(1, 2, 8'h00);
    wr(1, 3, 8'h09);
    pulse_lc();
    measure(0, hi, lo, lvl, ok);
    checks++;
    if (!ok || hi !== 256) begin errors++; $display("FAIL sweep_neg_ones: got %0d expected 256", hi); end
    measure(1, hi, lo, lvl, ok);
    checks++;
    if (!ok || hi !== 258) begin errors++; $display("FAIL sweep_neg_twos: got %0d expected 258", hi); end
  endtask

  task automatic test_mute();
    cpu = 1'b0;
    en = 4'b0001;
    wr(0, 0, 8'hFF);
    wr(0, 1, 8'h00);
    wr(0, 2, 8'h08);
    wr(0, 3, 8'h08);
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd15) begin errors++; $display("FAIL mute_period8: got %0d expected 15", pulse[3:0]); end
    wr(0, 2, 8'h07);
    wr(0, 3, 8'h08);
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd0) begin errors++; $display("FAIL mute_period7: got %0d expected 0", pulse[3:0]); end
    wr(0, 1, 8'h01);
    wr(0, 2, 8'hFF);
    wr(0, 3, 8'h0B);
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd15) begin errors++; $display("FAIL mute_3ff: got %0d expected 15", pulse[3:0]); end
    wr(0, 3, 8'h0F);
    idle(1);
    checks++;
    if (pulse[3:0] !== 4'd0) begin errors++; $display("FAIL mute_overflow: got %0d expected 0", pulse[3:0]); end
    checks++;
    if (active[0] !== 1'b1) begin errors++; $display("FAIL mute_active: got %b expected 1", active[0]); end
  endtask

  task automatic test_address();
    cpu = 1'b0;
    en = 4'b0000;
    idle(1);
    en = 4'b1111;
    wr_addr(16'h500C, 8'hF5, 1'b0);
    wr_addr(16'h500E, 8'h10, 1'b0);
    wr_addr(16'h500F, 8'h08, 1'b0);
    idle(1);
    checks++;
    if (active !== 4'b1000) begin errors++; $display("FAIL addr_active: got %b expected 1000", active); end
    checks++;
    if (pulse !== 16'h5000) begin errors++; $display("FAIL addr_pulse: got %h expected 5000", pulse); end
    wr_addr(16'h5010, 8'hFF, 1'b0);
    wr_addr(16'h5013, 8'h08, 1'b0);
    wr_addr(16'h4FFF, 8'h08, 1'b0);
    idle(1);
    checks++;
    if (active !== 4'b1000) begin errors++; $display("FAIL addr_outside_active: got %b expected 1000", active); end
    checks++;
    if (pulse !== 16'h5000) begin errors++; $display("FAIL addr_outside_pulse: got %h expected 5000", pulse); end
    wr_addr(16'h500C, 8'hF9, 1'b0);
    idle(1);
    checks++;
    if (pulse !== 16'h9000) begin errors++; $display("FAIL addr_r0_ch3: got %h expected 9000", pulse); end
  endtask

  task automatic test_reset_mid_note();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pulse !== 16'h0000) begin errors++; $display("FAIL midreset_pulse: got %h expected 0000", pulse); end
    checks++;
    if (active !== 4'b0000) begin errors++; $display("FAIL midreset_active: got %b expected 0000", active); end
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_length();
    test_envelope();
    test_sweep();
    test_mute();
    test_address();
    test_reset_mid_note();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
